// File: rtl/dmem_pkg.sv
// Shared defaults, buffer entry layout and address helpers for the data-memory
// store buffer.
package dmem_pkg;

   localparam int DMEM_DEPTH = 4;
   localparam int DMEM_AW    = 32;
   localparam int DMEM_DW    = 32;

   // One buffered store: word index (byte address without its low two bits) and data.
   typedef struct packed {
      logic [DMEM_AW-3:0] widx;
      logic [DMEM_DW-1:0] data;
   } entry_t;

   function automatic logic [DMEM_AW-3:0] word_idx(input logic [DMEM_AW-1:0] addr);
      return addr[DMEM_AW-1:2];
   endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store FIFO: entry storage, head/tail pointers and an occupancy count
// that distinguishes full from empty.
module store_buffer_fifo
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int IW    = DMEM_AW - 2,
   parameter int DW    = DMEM_DW,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [IW-1:0] push_widx,
   input  logic [DW-1:0] push_data,
   output logic [IW-1:0] ent_widx [DEPTH],
   output logic [DW-1:0] ent_data [DEPTH],
   output logic [PW-1:0] head_ptr,
   output logic [PW-1:0] tail_ptr,
   output logic [PW:0]   count,
   output logic          full,
   output logic          empty
);

   logic do_push;
   logic do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Entry payload is deliberately left out of reset; validity comes from count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         ent_widx[tail_ptr] <= push_widx;
         ent_data[tail_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (do_push) tail_ptr <= tail_ptr + PW'(1);
         if (do_pop)  head_ptr <= head_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the core data port and data memory, with
// store-to-load forwarding from every buffered entry.
module dmem_store_buffer
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int AW    = DMEM_AW,
   parameter int DW    = DMEM_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          stall,
   output logic [AW-1:0] mem_raddr,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_req,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int IW = AW - 2;

   logic          push;
   logic          pop;
   logic          full;
   logic [IW-1:0] cpu_widx;
   logic [IW-1:0] ent_widx [DEPTH];
   logic [DW-1:0] ent_data [DEPTH];
   logic [PW-1:0] head_ptr;
   logic [PW-1:0] tail_ptr;
   logic [PW:0]   count;
   logic [PW-1:0] slot;
   logic          fwd_hit;

   // Write port handshake: mem_req is valid, mem_ack is ready. The head entry is
   // presented unchanged while mem_req=1 and retires on the edge where both are 1;
   // mem_ack while mem_req=0 has no effect.
   assign mem_req   = ~empty;
   assign pop       = mem_req & mem_ack;
   assign mem_waddr = {ent_widx[head_ptr], 2'b00};
   assign mem_wdata = ent_data[head_ptr];

   // Stall looks only at the registered full flag, so a same-cycle drain never
   // releases the core and mem_ack never reaches the stall path.
   assign stall = cpu_we & full;
   assign push  = cpu_we & ~full;

   assign mem_raddr = cpu_addr;
   assign cpu_widx  = cpu_addr[AW-1:2];

   store_buffer_fifo #(
      .DEPTH (DEPTH),
      .IW    (IW),
      .DW    (DW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_widx (cpu_widx),
      .push_data (cpu_wdata),
      .ent_widx  (ent_widx),
      .ent_data  (ent_data),
      .head_ptr  (head_ptr),
      .tail_ptr  (tail_ptr),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Walk back from the tail (k=1 is the youngest entry); the first hit wins.
   always_comb begin
      fwd_hit   = 1'b0;
      slot      = '0;
      cpu_rdata = mem_rdata;
      for (int k = 1; k <= DEPTH; k++) begin
         slot = tail_ptr - PW'(k);
         if (!fwd_hit && ((PW+1)'(k) <= count) && (ent_widx[slot] == cpu_widx)) begin
            fwd_hit   = 1'b1;
            cpu_rdata = ent_data[slot];
         end
      end
   end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write buffer between the MIPS core's data port and data memory. Stores from the single-cycle core are accepted into a small FIFO and drained to memory through a request/acknowledge write port, so a slow memory write does not lengthen the core cycle. Loads read memory through an asynchronous read port, with store-to-load forwarding from any buffered entry. The block stalls the core only when a store arrives while the buffer is full.

## Interface
- DEPTH, 4: buffer entries; power of two, at least 2.
- AW, 32: byte-address width; word index is addr[AW-1:2].
- DW, 32: data width.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cpu_we  in  1  store request from core (memwrite).
- cpu_addr  in  AW  byte address (aluout/dataadr).
- cpu_wdata  in  DW  store data (writedata).
- cpu_rdata  out  DW  load data to core (readdata).
- stall  out  1  core must hold its PC and the current instruction.
- mem_raddr  out  AW  async read address to memory; equals cpu_addr.
- mem_rdata  in  DW  async read data from memory.
- mem_req  out  1  write request to memory.
- mem_waddr  out  AW  write address; word-aligned, low 2 bits are 0.
- mem_wdata  out  DW  write data.
- mem_ack  in  1  memory accepted the write this cycle.
- empty  out  1  buffer holds no stores.

## Operation
- Circular FIFO of {word address[AW-3:0], data}, with head pointer, tail pointer, and count in the range 0..DEPTH.
- Push: when cpu_we=1 and stall=0, write {cpu_addr[AW-1:2], cpu_wdata} at the tail on the clock edge.
- stall = cpu_we and (count == DEPTH).
  - A pop in the same cycle does not clear stall.
  - stall must not depend combinationally on mem_ack.
- Drain: mem_req = (count != 0). mem_waddr and mem_wdata come from the head entry. Pop on the edge where mem_req=1 and mem_ack=1.
- mem_req/mem_waddr/mem_wdata stay stable until acknowledged. A mem_ack with mem_req=0 is ignored.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any count from 1 to DEPTH-1.
- Forwarding:
  - Compare cpu_addr[AW-1:2] against all valid entries.
  - On any match, cpu_rdata is the data of the youngest matching entry (closest to the tail); otherwise cpu_rdata = mem_rdata.
  - The head entry remains forwardable while it is being presented to memory, up to the edge that pops it.
- Repeated stores to the same address occupy separate entries; there is no coalescing. Memory sees the stores in program order.
- Pointers wrap modulo DEPTH.
- Reset (reset=0): count=0, both pointers=0, mem_req=0, empty=1, stall=0. Buffered stores are discarded. Entry data is not reset.

## Timing
- A store accepted at edge N appears on mem_req during cycle N+1, at the earliest.
- Store drain latency is 1 cycle plus the memory's ack delay per entry, plus the queueing delay behind older entries.
- Forwarded load data is combinational within the cycle after the store's push edge.
- The stall→core path is combinational from cpu_we and registered count.
- cpu_rdata is combinational from cpu_addr, the buffer contents, and mem_rdata.
- The async reset takes effect immediately: mem_req drops without waiting for a clock.

## Structure
- Shared package `dmem_pkg`: DEPTH/AW/DW defaults, the entry struct type, and a helper function for the word-index slice.
- Sub-module `store_buffer_fifo`: storage, pointers, count, full/empty.
- Top level `dmem_store_buffer`: stall logic, memory request mapping, and the forwarding priority mux across entries (youngest first, indexed relative to the tail).

## Test plan
- Reset, then a single store to 0x54 with data 0x0000_0007. Expect mem_req high from the next cycle with waddr=0x54 and wdata=7. Ack after 3 cycles → entry pops, empty=1.
- With mem_ack held 0, store DEPTH=4 entries, then a fifth store. Expect stall=1 on the fifth store until the cycle after the first ack. The fifth entry is then accepted, and memory order is 1,2,3,4,5.
- Stores to 0x10 of 0xAA and then 0xBB, both pending; load 0x10 → cpu_rdata=0xBB. Load 0x14 → cpu_rdata=mem_rdata.
- mem_ack every cycle with a store every cycle: push and pop happen in the same cycle, count stays at 1, and stall is never asserted.
- With 3 entries pending, pulse reset low between edges. Expect mem_req to drop immediately, empty=1, and no pending store to reach memory afterwards.
- Store to unaligned address 0x57 → mem_waddr=0x54. A later load from 0x54 forwards that store's data.
